panel_input_ctrl: RTL and testbench
===================================

Name: panel_input_ctrl

Overview:
Front-panel input block. It turns the raw push-buttons and slide switches into the `mode`/`msg` pair consumed by the digit display, and into the baud-rate select. In DATA_MODE it issues a one-byte valid/ready transmit request to the UART TX path. It is the writer side of the display's `mode`/`msg` interface and sits between board I/O and the UART/display blocks.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable src_clk cycles needed to accept a button level change (10 ms at 50 MHz); minimum 2.

Ports:
src_clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
btn_mode  input  1  raw button, active-high, asynchronous; press toggles mode
btn_baud  input  1  raw button, active-high, asynchronous; press advances baud select
btn_send  input  1  raw button, active-high, asynchronous; press sends sw byte
sw  input  8  raw slide switches, asynchronous; data byte
tx_ready  input  1  UART TX can accept a byte
tx_valid  output  1  transmit request
tx_data  output  8  byte to transmit, stable while tx_valid=1
baud_sel  output  2  current baud select code
mode  output  1  BAUDRATE_MODE / DATA_MODE, to display
msg  output  8  display payload
busy  output  1  send FSM not in IDLE

Behaviour:
- Reset values, applied asynchronously while rst_n=0: mode=BAUDRATE_MODE, baud_sel=SEL_9600, msg=8'h00, tx_valid=0, tx_data=8'h00, busy=0, FSM=IDLE.
- Reset internals: all synchronizer flops, debounced levels and debounce counters = 0.
- Reset mid-send drops tx_valid at once. No byte is owed after reset release.
- Input sync: each button and all 8 sw bits pass through 2 flops.
- Debounce, per button:
  - Counter clears whenever the synced value equals the debounced level.
  - Otherwise it increments.
  - When counter = DEBOUNCE_CYCLES-1 and the value still differs, the debounced level flips on the next edge and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never flips the level.
- Press pulse: one-cycle pulse, registered, on the cycle after the debounced 0->1 flip.
  - Latency from the raw rising edge to the pulse = 2 + DEBOUNCE_CYCLES + 1 cycles.
  - Release (1->0) produces no pulse.
- Mode:
  - A mode pulse toggles mode, but only while FSM=IDLE.
  - A mode pulse while busy is dropped, not queued.
- Baud select:
  - A baud pulse with mode=BAUDRATE_MODE steps SEL_9600 -> SEL_57600 -> SEL_115200 -> SEL_9600.
  - The pulse is ignored in DATA_MODE.
  - baud_sel is held across mode changes.
- msg, registered:
  - BAUDRATE_MODE: msg = {6'b0, baud_sel}.
  - DATA_MODE with FSM=IDLE: msg = synced sw.
  - DATA_MODE with FSM not IDLE: msg = tx_data.
- Send FSM:
  - IDLE: on a send pulse with mode=DATA_MODE, capture synced sw into tx_data and go to REQ. A send pulse in BAUDRATE_MODE is ignored.
  - REQ: tx_valid=1. tx_data is frozen. On the cycle tx_valid&tx_ready=1, go to RELEASE. tx_valid may be held indefinitely; there is no timeout.
  - RELEASE: tx_valid=0. Return to IDLE once the debounced btn_send level is 0. Holding the button gives exactly one byte.
  - busy=1 in REQ and RELEASE.
- Simultaneous pulses in the same cycle:
  - Send and mode, in DATA_MODE idle: the send is taken and the mode toggle is dropped.
  - Baud and mode, in BAUDRATE_MODE: the baud step is applied, then mode toggles. Both take effect on that edge.
  - Send with tx_ready already 1: REQ lasts exactly 1 cycle.
- Baud select codes must never take the value 2'b11.

Decomposition:
- common.v holds BAUDRATE_MODE=1'b0, DATA_MODE=1'b1, SEL_9600=2'd0, SEL_57600=2'd1, SEL_115200=2'd2.
- common.v also holds the FSM state encodings PIC_IDLE/PIC_REQ/PIC_RELEASE (2 bits).
- Sub-module `debounce`: sync + counter + level + rise pulse, parameter DEBOUNCE_CYCLES. Instantiated three times, once per button.
- The sw bus uses plain 2-flop sync, not debounce.

Test Plan (DEBOUNCE_CYCLES=4):
1. Reset, then btn_baud held 10 cycles in BAUDRATE_MODE -> single pulse at cycle 7 after the raw edge; baud_sel=1, msg=8'h01. Two more presses -> baud_sel 2, then 0.
2. btn_baud glitch high for 3 cycles -> no pulse, baud_sel unchanged.
3. Mode press, then sw=8'h41 -> mode=DATA_MODE, msg=8'h41. Baud press -> baud_sel unchanged.
4. sw=8'h5A, tx_ready=0, send press held 50 cycles -> tx_valid=1, tx_data=8'h5A.
   - Change sw to 8'h00 -> tx_data and msg stay 8'h5A.
   - Raise tx_ready for 1 cycle -> tx_valid falls next cycle; exactly one handshake.
   - busy stays 1 until release is debounced.
5. Mode press during REQ -> mode stays DATA_MODE; after return to IDLE a new mode press -> BAUDRATE_MODE, msg={6'b0,baud_sel}.
6. rst_n pulled low during REQ -> tx_valid=0 and busy=0 immediately, mode=BAUDRATE_MODE, baud_sel=0. No tx_valid after release without a new press.

Source files
------------

// File: rtl/panel_input_ctrl_pkg.sv
`default_nettype none
// panel_input_ctrl_pkg: mode, baud-select and send-FSM encodings shared by the panel input block.
// Revision: 1.0
package panel_input_ctrl_pkg;

  localparam logic       BAUDRATE_MODE = 1'b0;
  localparam logic       DATA_MODE     = 1'b1;

  localparam logic [1:0] SEL_9600      = 2'd0;
  localparam logic [1:0] SEL_57600     = 2'd1;
  localparam logic [1:0] SEL_115200    = 2'd2;

  typedef enum logic [1:0] {
    PIC_IDLE    = 2'd0,
    PIC_REQ     = 2'd1,
    PIC_RELEASE = 2'd2
  } pic_state_t;

  // Any unexpected code falls back to 9600 so 2'b11 can never persist.
  function automatic logic [1:0] next_baud_sel(input logic [1:0] sel);
    case (sel)
      SEL_9600:  next_baud_sel = SEL_57600;
      SEL_57600: next_baud_sel = SEL_115200;
      default:   next_baud_sel = SEL_9600;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/panel_input_ctrl_debounce.sv
`default_nettype none
// panel_input_ctrl_debounce: 2-flop sync, stability counter, debounced level and registered rise pulse.
// Revision: 1.0
module panel_input_ctrl_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int             CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_1;
  logic             sync_2;
  logic [CNT_W-1:0] cnt;
  logic             level_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
    end
  end

  // The counter only runs while the synced input disagrees with the accepted level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync_2 == level) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      level <= sync_2;
      cnt   <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_d <= 1'b0;
      rise    <= 1'b0;
    end else begin
      level_d <= level;
      rise    <= level & ~level_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/panel_input_ctrl.sv
`default_nettype none
// panel_input_ctrl: turns panel buttons/switches into display mode/msg, baud select and a UART TX request.
// Revision: 1.0
module panel_input_ctrl
  import panel_input_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       src_clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_baud,
  input  logic       btn_send,
  input  logic [7:0] sw,
  input  logic       tx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic [1:0] baud_sel,
  output logic       mode,
  output logic [7:0] msg,
  output logic       busy
);

  logic       mode_pulse;
  logic       baud_pulse;
  logic       send_pulse;
  logic       mode_level;
  logic       baud_level;
  logic       send_level;
  logic       unused_levels;
  logic [7:0] sw_s1;
  logic [7:0] sw_s2;
  logic       capture;
  pic_state_t state;
  pic_state_t state_next;

  panel_input_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbnc_mode (
    .clk   (src_clk),
    .rst_n (rst_n),
    .raw   (btn_mode),
    .level (mode_level),
    .rise  (mode_pulse)
  );

  panel_input_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbnc_baud (
    .clk   (src_clk),
    .rst_n (rst_n),
    .raw   (btn_baud),
    .level (baud_level),
    .rise  (baud_pulse)
  );

  panel_input_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbnc_send (
    .clk   (src_clk),
    .rst_n (rst_n),
    .raw   (btn_send),
    .level (send_level),
    .rise  (send_pulse)
  );

  assign unused_levels = mode_level ^ baud_level;

  // Switches are a data bus sampled on demand, so plain synchronization is enough.
  always_ff @(posedge src_clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_s1 <= 8'h00;
      sw_s2 <= 8'h00;
    end else begin
      sw_s1 <= sw;
      sw_s2 <= sw_s1;
    end
  end

  always_ff @(posedge src_clk or negedge rst_n) begin
    if (!rst_n) state <= PIC_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    case (state)
      PIC_IDLE: begin
        if (send_pulse && (mode == DATA_MODE)) begin
          state_next = PIC_REQ;
          capture    = 1'b1;
        end
      end
      PIC_REQ: begin
        if (tx_ready) state_next = PIC_RELEASE;
      end
      PIC_RELEASE: begin
        // Wait for the button to be let go so a held press sends only one byte.
        if (!send_level) state_next = PIC_IDLE;
      end
      default: state_next = PIC_IDLE;
    endcase
  end

  assign tx_valid = (state == PIC_REQ);
  assign busy     = (state != PIC_IDLE);

  always_ff @(posedge src_clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data <= 8'h00;
    end else if (capture) begin
      tx_data <= sw_s2;
    end
  end

  // A send pulse wins over a simultaneous mode pulse; mode never changes mid-send.
  always_ff @(posedge src_clk or negedge rst_n) begin
    if (!rst_n) begin
      mode     <= BAUDRATE_MODE;
      baud_sel <= SEL_9600;
    end else begin
      if (baud_pulse && (mode == BAUDRATE_MODE)) begin
        baud_sel <= next_baud_sel(baud_sel);
      end
      if (mode_pulse && (state == PIC_IDLE) && !capture) begin
        mode <= ~mode;
      end
    end
  end

  always_ff @(posedge src_clk or negedge rst_n) begin
    if (!rst_n) begin
      msg <= 8'h00;
    end else if (mode == BAUDRATE_MODE) begin
      msg <= {6'b0, baud_sel};
    end else if (state == PIC_IDLE) begin
      msg <= sw_s2;
    end else begin
      msg <= tx_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_panel_input_ctrl.sv
`default_nettype none
// tb_panel_input_ctrl: directed table-driven bench for panel_input_ctrl with DEBOUNCE_CYCLES=4.
// Revision: 1.0
module tb_panel_input_ctrl;
  import panel_input_ctrl_pkg::*;

  localparam int DB = 4;

  logic       src_clk = 1'b0;
  logic       rst_n;
  logic       btn_mode;
  logic       btn_baud;
  logic       btn_send;
  logic [7:0] sw;
  logic       tx_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic [1:0] baud_sel;
  logic       mode;
  logic [7:0] msg;
  logic       busy;

  int checks = 0;
  int fails  = 0;
  int hs_count = 0;
  int valid_cycles = 0;

  typedef struct {
    logic [2:0] mask;     // {send, baud, mode}
    int         hold;
    logic [7:0] swv;
    logic       exp_mode;
    logic [1:0] exp_baud;
    logic [7:0] exp_msg;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[11];

  panel_input_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
    .src_clk  (src_clk),
    .rst_n    (rst_n),
    .btn_mode (btn_mode),
    .btn_baud (btn_baud),
    .btn_send (btn_send),
    .sw       (sw),
    .tx_ready (tx_ready),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .baud_sel (baud_sel),
    .mode     (mode),
    .msg      (msg),
    .busy     (busy)
  );

  always #5 src_clk = ~src_clk;

  always @(posedge src_clk) begin
    if (tx_valid && tx_ready) hs_count <= hs_count + 1;
    if (tx_valid) valid_cycles <= valid_cycles + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge src_clk);
    #1;
  endtask

  task automatic press(input logic [2:0] mask, input int hold);
    {btn_send, btn_baud, btn_mode} = mask;
    tick(hold);
    {btn_send, btn_baud, btn_mode} = 3'b000;
    tick(15);
  endtask

  initial begin
    int v0;
    int hs0;
    int n;

    vecs[0]  = '{3'b010, 10, 8'h00, 1'b0, 2'd2, 8'h02, 1'b0};
    vecs[1]  = '{3'b010, 10, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0};
    vecs[2]  = '{3'b010,  3, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0};  // glitch
    vecs[3]  = '{3'b010, 10, 8'h00, 1'b0, 2'd1, 8'h01, 1'b0};
    vecs[4]  = '{3'b001, 10, 8'h41, 1'b1, 2'd1, 8'h41, 1'b0};
    vecs[5]  = '{3'b010, 10, 8'h41, 1'b1, 2'd1, 8'h41, 1'b0};  // baud ignored in data mode
    vecs[6]  = '{3'b001, 10, 8'h41, 1'b0, 2'd1, 8'h01, 1'b0};
    vecs[7]  = '{3'b100, 10, 8'h41, 1'b0, 2'd1, 8'h01, 1'b0};  // send ignored in baud mode
    vecs[8]  = '{3'b011, 10, 8'h00, 1'b1, 2'd2, 8'h00, 1'b0};  // baud step and mode toggle together
    vecs[9]  = '{3'b001, 10, 8'h00, 1'b0, 2'd2, 8'h02, 1'b0};
    vecs[10] = '{3'b001, 10, 8'h5A, 1'b1, 2'd2, 8'h5A, 1'b0};

    rst_n = 1'b0; btn_mode = 1'b0; btn_baud = 1'b0; btn_send = 1'b0;
    sw = 8'h00; tx_ready = 1'b0;
    tick(3);
    check("rst_mode",     32'(mode),     32'(BAUDRATE_MODE));
    check("rst_baud_sel", 32'(baud_sel), 32'(SEL_9600));
    check("rst_msg",      32'(msg),      32'h00);
    check("rst_tx_valid", 32'(tx_valid), 32'h0);
    check("rst_tx_data",  32'(tx_data),  32'h00);
    check("rst_busy",     32'(busy),     32'h0);
    rst_n = 1'b1;
    tick(2);

    // First baud press: pulse after edge 7, baud_sel moves on edge 8, msg on edge 9.
    btn_baud = 1'b1;
    tick(7);
    check("baud_before_pulse", 32'(baud_sel), 32'd0);
    tick(1);
    check("baud_at_pulse", 32'(baud_sel), 32'd1);
    tick(1);
    check("msg_after_baud", 32'(msg), 32'h01);
    tick(7);
    btn_baud = 1'b0;
    tick(15);
    check("baud_single_pulse", 32'(baud_sel), 32'd1);

    for (int i = 0; i < 11; i++) begin
      sw = vecs[i].swv;
      press(vecs[i].mask, vecs[i].hold);
      check($sformatf("vec%0d_mode", i), 32'(mode),     32'(vecs[i].exp_mode));
      check($sformatf("vec%0d_baud", i), 32'(baud_sel), 32'(vecs[i].exp_baud));
      check($sformatf("vec%0d_msg", i),  32'(msg),      32'(vecs[i].exp_msg));
      check($sformatf("vec%0d_busy", i), 32'(busy),     32'(vecs[i].exp_busy));
    end

    // Held send with tx_ready low, sw change, mode press during REQ, one-cycle ready.
    hs0 = hs_count;
    btn_send = 1'b1;
    tick(12);
    check("req_tx_valid", 32'(tx_valid), 32'h1);
    check("req_tx_data",  32'(tx_data),  32'h5A);
    check("req_busy",     32'(busy),     32'h1);
    sw = 8'h00;
    tick(5);
    check("req_data_frozen", 32'(tx_data), 32'h5A);
    check("req_msg_frozen",  32'(msg),     32'h5A);
    btn_mode = 1'b1;
    tick(10);
    btn_mode = 1'b0;
    tick(10);
    check("mode_dropped_in_req", 32'(mode),     32'h1);
    check("req_still_valid",     32'(tx_valid), 32'h1);
    tx_ready = 1'b1;
    tick(1);
    tx_ready = 1'b0;
    check("valid_falls", 32'(tx_valid), 32'h0);
    check("release_busy", 32'(busy), 32'h1);
    tick(12);
    check("held_busy", 32'(busy), 32'h1);
    check("held_no_valid", 32'(tx_valid), 32'h0);
    btn_send = 1'b0;
    tick(15);
    check("idle_busy", 32'(busy), 32'h0);
    check("one_handshake", 32'(hs_count - hs0), 32'd1);
    check("idle_msg_sw", 32'(msg), 32'h00);
    check("idle_mode", 32'(mode), 32'h1);

    // Send and mode together with tx_ready already high: send wins, REQ lasts 1 cycle.
    sw = 8'hC3;
    tx_ready = 1'b1;
    tick(3);
    v0 = valid_cycles;
    hs0 = hs_count;
    {btn_send, btn_mode} = 2'b11;
    tick(12);
    check("combo_busy", 32'(busy), 32'h1);
    check("combo_valid", 32'(tx_valid), 32'h0);
    check("combo_mode", 32'(mode), 32'h1);
    check("combo_data", 32'(tx_data), 32'hC3);
    {btn_send, btn_mode} = 2'b00;
    tick(15);
    check("combo_req_cycles", 32'(valid_cycles - v0), 32'd1);
    check("combo_handshakes", 32'(hs_count - hs0), 32'd1);
    check("combo_idle", 32'(busy), 32'h0);
    tx_ready = 1'b0;

    press(3'b001, 10);
    check("back_to_baud_mode", 32'(mode), 32'(BAUDRATE_MODE));
    check("back_msg", 32'(msg), 32'h02);

    // Reset in the middle of a request.
    press(3'b001, 10);
    check("data_mode_again", 32'(mode), 32'(DATA_MODE));
    sw = 8'h33;
    btn_send = 1'b1;
    n = 0;
    while (!tx_valid && n < 30) begin
      tick(1);
      n++;
    end
    check("reached_req", 32'(tx_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_tx_valid", 32'(tx_valid), 32'h0);
    check("arst_busy",     32'(busy),     32'h0);
    check("arst_mode",     32'(mode),     32'(BAUDRATE_MODE));
    check("arst_baud",     32'(baud_sel), 32'(SEL_9600));
    check("arst_tx_data",  32'(tx_data),  32'h00);
    btn_send = 1'b0;
    tick(3);
    v0 = valid_cycles;
    rst_n = 1'b1;
    tick(25);
    check("no_owed_byte", 32'(valid_cycles - v0), 32'd0);
    check("post_rst_busy", 32'(busy), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
